dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit in cycles, range 1..255, used only under REQ-027.
REQ-003 SHALL have ports, in this order:
 clk  in  1  clock; all state updates on rising edge.
 reset  in  1  reset, synchronous, active-high.
 core_addr  in  XLEN  datapath data address (byte).
 core_wdata  in  XLEN  lane-aligned store data.
 core_wstrb  in  4  byte-lane enables for store.
 core_we  in  1  store request.
 core_re  in  1  load request.
 core_rdata  out  XLEN  load result to datapath.
 core_stall  out  1  holds datapath PC and register writeback.
 core_err  out  1  sticky bus error.
 bus_req_valid  out  1  request valid.
 bus_req_ready  in  1  request accepted.
 bus_addr  out  XLEN  word-aligned request address.
 bus_wdata  out  XLEN  request write data.
 bus_wstrb  out  4  request byte enables, 0 for loads.
 bus_we  out  1  1 = write.
 bus_resp_valid  in  1  response valid.
 bus_resp_data  in  XLEN  read data.
 bus_resp_err  in  1  response error.

Function
REQ-004 SHALL implement FSM states IDLE, REQ, RESP, DONE.
REQ-005 access = core_re | core_we; core_we takes priority if both are set.
REQ-006 IDLE and access: latch {core_addr[XLEN-1:2],2'b00}, core_wdata, core_wstrb (0 if load), core_we into bus_* registers; go to REQ.
REQ-007 REQ: bus_req_valid = 1; bus_* held stable until bus_req_ready = 1, then go to RESP.
REQ-008 RESP: bus_req_valid = 0; on bus_resp_valid, capture bus_resp_data (0 if bus_resp_err) into rdata register; go to DONE.
REQ-009 bus_resp_valid SHALL be ignored in IDLE, REQ and DONE.
REQ-010 DONE: core_stall = 0 for exactly one cycle; core_rdata = captured value; then go to IDLE.
REQ-011 core_stall = access & (state != DONE), combinational; 0 when no access.
REQ-012 Zero-wait bus (ready in REQ, response the next cycle): stall for 3 cycles, result in the 4th.
REQ-013 The FSM SHALL return to IDLE after DONE without starting a new access, even if access is still asserted in DONE.
REQ-014 bus_resp_err = 1 in RESP SHALL set core_err, which stays 1 until reset.
REQ-015 Stores SHALL complete through RESP like loads; core_rdata is then undefined and is not written back.
REQ-016 core_rdata SHALL hold its value outside DONE.
REQ-017 Request and response SHALL NOT complete in the same cycle; a response is valid only from the cycle after acceptance.

Reset
REQ-018 On reset: state = IDLE and bus_req_valid = 0 from the next cycle.
REQ-019 On reset: bus_addr, bus_wdata, bus_wstrb, bus_we, core_rdata and core_err = 0.
REQ-020 Reset asserted mid-access SHALL abandon the transaction; a late bus_resp_valid is ignored per REQ-009.
REQ-021 During reset: core_stall = access, and the datapath's own reset governs.

Configuration
REQ-027 Macro DMEM_BRIDGE_TIMEOUT_EN:
 defined: 8-bit counter, cleared on IDLE->REQ, increments each cycle in REQ/RESP; on reaching TIMEOUT_CYCLES: set core_err, core_rdata = 0, bus_req_valid = 0, go to DONE.
 undefined: no counter; the FSM waits indefinitely; TIMEOUT_CYCLES unused.

Verification
REQ-030 Load, addr 0x103, ready immediately, resp 0xDEADBEEF next cycle -> bus_addr 0x100, wstrb 0, stall 3 cycles, core_rdata 0xDEADBEEF in cycle 4.
REQ-031 Store 0x000000AB, wstrb 0001, ready after 5 cycles -> bus_* stable for all 5 cycles, bus_we 1, stall released one cycle after the response.
REQ-032 Load with bus_resp_err = 1 -> core_rdata 0, core_err 1; core_err stays 1 through 10 further good accesses until reset.
REQ-033 Reset during RESP, then bus_resp_valid after reset -> state IDLE, response ignored, core_rdata 0.
REQ-034 Back-to-back loads to 0x0 and 0x4 -> two separate transactions, one DONE cycle each, no merged request.
REQ-035 With DMEM_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES = 16, bus_req_ready held 0 -> after 16 cycles core_err 1, DONE, bus_req_valid 0.

Source files
------------

// File: rtl/dmem_bridge.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_bridge
//
// Bridges the core's single-cycle data-memory port onto a valid/ready request
// bus with a separate response channel. The core is stalled while an access
// is in flight and released for exactly one cycle when the result is ready.
//
// Optional build macro:
//   DMEM_BRIDGE_TIMEOUT_EN - adds an 8-bit watchdog. It aborts an access that
//                            spends TIMEOUT_CYCLES cycles in REQ/RESP, flags
//                            core_err and returns zero read data.
//
// Parameters:
//   XLEN           - data and address width
//   TIMEOUT_CYCLES - watchdog limit (1..255), used only with the macro above
//
// Ports:
//   clk, reset      - clock; synchronous active-high reset
//   core_addr       - byte address from the datapath
//   core_wdata      - lane-aligned store data
//   core_wstrb      - byte-lane enables for stores
//   core_we/core_re - store / load request (store wins if both are set)
//   core_rdata      - load result, updated only when a response is captured
//   core_stall      - holds datapath PC and register writeback
//   core_err        - sticky bus error, cleared only by reset
//   bus_req_valid   - request valid, held until bus_req_ready
//   bus_req_ready   - request accepted
//   bus_addr        - word-aligned request address
//   bus_wdata       - request write data
//   bus_wstrb       - request byte enables, zero for loads
//   bus_we          - 1 = write
//   bus_resp_valid  - response valid (only honoured while waiting for it)
//   bus_resp_data   - read data
//   bus_resp_err    - response error
// -----------------------------------------------------------------------------
module dmem_bridge #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] core_addr,
  input  logic [XLEN-1:0] core_wdata,
  input  logic [3:0]      core_wstrb,
  input  logic            core_we,
  input  logic            core_re,
  output logic [XLEN-1:0] core_rdata,
  output logic            core_stall,
  output logic            core_err,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_wstrb,
  output logic            bus_we,
  input  logic            bus_resp_valid,
  input  logic [XLEN-1:0] bus_resp_data,
  input  logic            bus_resp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_t;

  state_t            r_state;
  logic              r_bus_req_valid;
  logic [XLEN-1:0]   r_bus_addr;
  logic [XLEN-1:0]   r_bus_wdata;
  logic [3:0]        r_bus_wstrb;
  logic              r_bus_we;
  logic [XLEN-1:0]   r_rdata;
  logic              r_err;

  logic              w_access;
  logic              w_timeout;
  logic              w_unused;

  assign w_access = core_re | core_we;

  // Byte offset is dropped (bus is word addressed); the timeout limit is only
  // consumed when the watchdog is built in.
  assign w_unused = ^{core_addr[1:0], TIMEOUT_CYCLES[0]};

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] LP_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_timeout_cnt;

  // Fires on the cycle that would make TIMEOUT_CYCLES cycles spent in REQ/RESP.
  assign w_timeout = (r_timeout_cnt == LP_TIMEOUT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: all state below is a handful of flops (no memory array), so every
  // register is reset and every update uses non-blocking assignment so that
  // all flops see the pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_bus_req_valid <= 1'b0;
      r_bus_addr      <= '0;
      r_bus_wdata     <= '0;
      r_bus_wstrb     <= 4'b0;
      r_bus_we        <= 1'b0;
      r_rdata         <= '0;
      r_err           <= 1'b0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
      r_timeout_cnt   <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_bus_addr      <= {core_addr[XLEN-1:2], 2'b00};
            r_bus_wdata     <= core_wdata;
            r_bus_wstrb     <= core_we ? core_wstrb : 4'b0;
            r_bus_we        <= core_we;
            r_bus_req_valid <= 1'b1;
            r_state         <= S_REQ;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
            r_timeout_cnt   <= 8'd0;
`endif
          end
        end

        S_REQ: begin
`ifdef DMEM_BRIDGE_TIMEOUT_EN
          r_timeout_cnt <= r_timeout_cnt + 8'd1;
`endif
          // A handshake on the final watchdog cycle still wins.
          if (bus_req_ready) begin
            r_bus_req_valid <= 1'b0;
            r_state         <= S_RESP;
          end else if (w_timeout) begin
            r_bus_req_valid <= 1'b0;
            r_err           <= 1'b1;
            r_rdata         <= '0;
            r_state         <= S_DONE;
          end
        end

        S_RESP: begin
`ifdef DMEM_BRIDGE_TIMEOUT_EN
          r_timeout_cnt <= r_timeout_cnt + 8'd1;
`endif
          // Captured for stores too; the datapath simply does not write it back.
          if (bus_resp_valid) begin
            r_rdata <= bus_resp_err ? '0 : bus_resp_data;
            if (bus_resp_err) begin
              r_err <= 1'b1;
            end
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_state <= S_DONE;
          end
        end

        // One release cycle; a still-asserted access is the next instruction
        // and is picked up from IDLE.
        S_DONE: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Held while reset is asserted so the datapath cannot advance past a
  // memory instruction before its own reset takes over.
  assign core_stall    = w_access & (reset | (r_state != S_DONE));

  assign core_rdata    = r_rdata;
  assign core_err      = r_err;
  assign bus_req_valid = r_bus_req_valid;
  assign bus_addr      = r_bus_addr;
  assign bus_wdata     = r_bus_wdata;
  assign bus_wstrb     = r_bus_wstrb;
  assign bus_we        = r_bus_we;

endmodule

// File: tb/tb_dmem_bridge.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_dmem_bridge
//
// Directed scenarios against dmem_bridge. Inputs are driven and outputs are
// sampled on the falling clock edge; the DUT updates on the rising edge.
// -----------------------------------------------------------------------------
module tb_dmem_bridge;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam int LP_TIMEOUT = 16;
`else
  localparam int LP_TIMEOUT = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_wstrb;
  logic        core_we;
  logic        core_re;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        core_err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_we;
  logic        bus_resp_valid;
  logic [31:0] bus_resp_data;
  logic        bus_resp_err;

  int n_pass  = 0;
  int n_total = 0;

  dmem_bridge #(
    .XLEN          (32),
    .TIMEOUT_CYCLES(LP_TIMEOUT)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_wstrb    (core_wstrb),
    .core_we       (core_we),
    .core_re       (core_re),
    .core_rdata    (core_rdata),
    .core_stall    (core_stall),
    .core_err      (core_err),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_wstrb     (bus_wstrb),
    .bus_we        (bus_we),
    .bus_resp_valid(bus_resp_valid),
    .bus_resp_data (bus_resp_data),
    .bus_resp_err  (bus_resp_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    core_re        = 1'b0;
    core_we        = 1'b0;
    core_addr      = '0;
    core_wdata     = '0;
    core_wstrb     = 4'b0;
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b0;
    bus_resp_data  = '0;
    bus_resp_err   = 1'b0;
  endtask

  // Runs one access against a small bus responder: ready after ready_delay
  // cycles of valid, response the cycle after acceptance. Returns the read
  // data seen in the release cycle and the number of stalled cycles.
  task automatic do_access(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input int ready_delay, input logic [31:0] resp_data,
                           input logic resp_err, output logic [31:0] rdata_out,
                           output int stalls, output bit timed_out);
    int  waited;
    bit  accept_next;
    bit  accepted;
    stalls      = 0;
    waited      = 0;
    accept_next = 1'b0;
    accepted    = 1'b0;
    timed_out   = 1'b1;
    core_we     = we;
    core_re     = ~we;
    core_addr   = addr;
    core_wdata  = wdata;
    core_wstrb  = wstrb;
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b0;
    bus_resp_err   = 1'b0;
    bus_resp_data  = '0;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (!core_stall) begin
        timed_out = 1'b0;
        break;
      end
      stalls++;
      if (accept_next) accepted = 1'b1;
      bus_req_ready  = 1'b0;
      bus_resp_valid = 1'b0;
      accept_next    = 1'b0;
      if (accepted) begin
        bus_resp_valid = 1'b1;
        bus_resp_data  = resp_data;
        bus_resp_err   = resp_err;
      end else if (bus_req_valid) begin
        if (waited >= ready_delay) begin
          bus_req_ready = 1'b1;
          accept_next   = 1'b1;
        end
        waited++;
      end
      tick();
    end
    rdata_out = core_rdata;
    idle_inputs();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    n_total++; if (bus_req_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", bus_req_valid); else n_pass++;
    n_total++; if ({bus_addr, bus_wdata, bus_wstrb, bus_we} !== 69'd0)
      $display("FAIL rst_bus_regs: got addr=%h wdata=%h wstrb=%b we=%b want all 0", bus_addr, bus_wdata, bus_wstrb, bus_we);
    else n_pass++;
    n_total++; if (core_rdata !== 32'd0) $display("FAIL rst_rdata: got %h want 0", core_rdata); else n_pass++;
    n_total++; if (core_err !== 1'b0) $display("FAIL rst_err: got %0b want 0", core_err); else n_pass++;
    n_total++; if (core_stall !== 1'b0) $display("FAIL rst_stall_noaccess: got %0b want 0", core_stall); else n_pass++;
    core_re = 1'b1;
    #1;
    n_total++; if (core_stall !== 1'b1) $display("FAIL rst_stall_access: got %0b want 1", core_stall); else n_pass++;
    core_re = 1'b0;
    reset   = 1'b0;
    tick();
    n_total++; if ({bus_req_valid, core_stall} !== 2'b00) $display("FAIL post_rst_idle: got valid,stall=%b want 00", {bus_req_valid, core_stall}); else n_pass++;
  endtask

  task automatic test_load();
    core_re       = 1'b1;
    core_addr     = 32'h0000_0103;
    bus_req_ready = 1'b1;
    #1;
    n_total++; if (core_stall !== 1'b1) $display("FAIL load_stall_c1: got %0b want 1", core_stall); else n_pass++;
    tick();
    n_total++; if ({bus_req_valid, bus_we, bus_wstrb} !== 6'b1_0_0000)
      $display("FAIL load_req_ctl: got valid=%b we=%b wstrb=%b want 1 0 0000", bus_req_valid, bus_we, bus_wstrb);
    else n_pass++;
    n_total++; if (bus_addr !== 32'h0000_0100) $display("FAIL load_addr: got %h want 00000100", bus_addr); else n_pass++;
    n_total++; if (core_stall !== 1'b1) $display("FAIL load_stall_c2: got %0b want 1", core_stall); else n_pass++;
    tick();
    n_total++; if ({bus_req_valid, core_stall} !== 2'b01) $display("FAIL load_resp_wait: got valid,stall=%b want 01", {bus_req_valid, core_stall}); else n_pass++;
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b1;
    bus_resp_data  = 32'hDEAD_BEEF;
    tick();
    n_total++; if (core_stall !== 1'b0) $display("FAIL load_release_c4: got %0b want 0", core_stall); else n_pass++;
    n_total++; if (core_rdata !== 32'hDEAD_BEEF) $display("FAIL load_rdata: got %h want deadbeef", core_rdata); else n_pass++;
    idle_inputs();
    tick();
    n_total++; if (core_rdata !== 32'hDEAD_BEEF) $display("FAIL load_rdata_hold: got %h want deadbeef", core_rdata); else n_pass++;
    n_total++; if (bus_req_valid !== 1'b0) $display("FAIL load_back_idle: got valid %0b want 0", bus_req_valid); else n_pass++;
  endtask

  // Store with ready after five cycles of valid; stray erroring responses
  // during REQ must be ignored and core inputs may change behind the latch.
  task automatic test_store();
    core_we       = 1'b1;
    core_addr     = 32'h0000_0020;
    core_wdata    = 32'h0000_00AB;
    core_wstrb    = 4'b0001;
    bus_req_ready = 1'b0;
    tick();
    for (int i = 1; i <= 5; i++) begin
      n_total++;
      if ({bus_req_valid, bus_addr, bus_wdata, bus_wstrb, bus_we, core_stall} !== {1'b1, 32'h20, 32'hAB, 4'b0001, 1'b1, 1'b1})
        $display("FAIL store_hold_c%0d: got valid=%b addr=%h wdata=%h wstrb=%b we=%b stall=%b want 1 00000020 000000ab 0001 1 1",
                 i, bus_req_valid, bus_addr, bus_wdata, bus_wstrb, bus_we, core_stall);
      else n_pass++;
      core_addr      = 32'h5555_0000 + i;
      core_wdata     = 32'hFFFF_FF00 | i;
      bus_resp_valid = (i < 5);
      bus_resp_err   = (i < 5);
      bus_resp_data  = 32'hBAD0_BAD0;
      if (i == 5) bus_req_ready = 1'b1;
      tick();
    end
    n_total++; if ({bus_req_valid, core_stall, core_err} !== 3'b010)
      $display("FAIL store_resp_wait: got valid,stall,err=%b want 010", {bus_req_valid, core_stall, core_err});
    else n_pass++;
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b1;
    bus_resp_err   = 1'b0;
    bus_resp_data  = 32'd0;
    tick();
    n_total++; if ({core_stall, core_err} !== 2'b00) $display("FAIL store_release: got stall,err=%b want 00", {core_stall, core_err}); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_error();
    logic [31:0] rd;
    int          st;
    bit          to;
    logic [31:0] exp_data;
    do_access(1'b0, 32'h40, 32'd0, 4'd0, 0, 32'h1234_5678, 1'b1, rd, st, to);
    n_total++; if (to !== 1'b0) $display("FAIL err_load_timeout: got timed_out=%0b want 0", to); else n_pass++;
    n_total++; if (rd !== 32'd0) $display("FAIL err_load_rdata: got %h want 0", rd); else n_pass++;
    n_total++; if (core_err !== 1'b1) $display("FAIL err_load_flag: got %0b want 1", core_err); else n_pass++;
    n_total++; if (st != 3) $display("FAIL err_load_stalls: got %0d want 3", st); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      exp_data = 32'hA5A5_0000 + i;
      do_access(1'b0, 32'h80 + 4 * i, 32'd0, 4'd0, i % 3, exp_data, 1'b0, rd, st, to);
      n_total++; if (rd !== exp_data || st != 3 + (i % 3))
        $display("FAIL err_good_%0d: got rdata=%h stalls=%0d want %h %0d", i, rd, st, exp_data, 3 + (i % 3));
      else n_pass++;
      n_total++; if (core_err !== 1'b1) $display("FAIL err_sticky_%0d: got %0b want 1", i, core_err); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    core_re       = 1'b1;
    core_addr     = 32'h0000_0200;
    bus_req_ready = 1'b1;
    tick();
    tick();
    bus_req_ready = 1'b0;
    reset         = 1'b1;
    tick();
    n_total++; if ({bus_req_valid, core_err, core_rdata, bus_addr} !== 66'd0)
      $display("FAIL midrst_clear: got valid=%b err=%b rdata=%h addr=%h want all 0", bus_req_valid, core_err, core_rdata, bus_addr);
    else n_pass++;
    n_total++; if (core_stall !== 1'b1) $display("FAIL midrst_stall: got %0b want 1", core_stall); else n_pass++;
    reset          = 1'b0;
    core_re        = 1'b0;
    bus_resp_valid = 1'b1;
    bus_resp_data  = 32'hCAFE_F00D;
    bus_resp_err   = 1'b1;
    tick();
    n_total++; if (core_rdata !== 32'd0) $display("FAIL midrst_late_rdata: got %h want 0", core_rdata); else n_pass++;
    n_total++; if ({core_err, bus_req_valid, core_stall} !== 3'b000)
      $display("FAIL midrst_late_idle: got err,valid,stall=%b want 000", {core_err, bus_req_valid, core_stall});
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  // Access held high across the release cycle: the second load must be a
  // separate request issued only after returning to IDLE.
  task automatic test_back_to_back();
    core_re       = 1'b1;
    core_addr     = 32'h0;
    bus_req_ready = 1'b1;
    tick();
    n_total++; if ({bus_req_valid, bus_addr} !== {1'b1, 32'h0}) $display("FAIL b2b_req0: got valid=%b addr=%h want 1 00000000", bus_req_valid, bus_addr); else n_pass++;
    tick();
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b1;
    bus_resp_data  = 32'h1111_1111;
    tick();
    n_total++; if ({core_stall, core_rdata} !== {1'b0, 32'h1111_1111}) $display("FAIL b2b_done0: got stall=%b rdata=%h want 0 11111111", core_stall, core_rdata); else n_pass++;
    core_addr      = 32'h4;
    bus_resp_valid = 1'b0;
    bus_req_ready  = 1'b1;
    tick();
    n_total++; if ({bus_req_valid, core_stall} !== 2'b01) $display("FAIL b2b_gap: got valid,stall=%b want 01", {bus_req_valid, core_stall}); else n_pass++;
    tick();
    n_total++; if ({bus_req_valid, bus_addr} !== {1'b1, 32'h4}) $display("FAIL b2b_req1: got valid=%b addr=%h want 1 00000004", bus_req_valid, bus_addr); else n_pass++;
    tick();
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b1;
    bus_resp_data  = 32'h2222_2222;
    tick();
    n_total++; if ({core_stall, core_rdata} !== {1'b0, 32'h2222_2222}) $display("FAIL b2b_done1: got stall=%b rdata=%h want 0 22222222", core_stall, core_rdata); else n_pass++;
    idle_inputs();
    tick();
    n_total++; if ({bus_req_valid, core_rdata} !== {1'b0, 32'h2222_2222}) $display("FAIL b2b_idle: got valid=%b rdata=%h want 0 22222222", bus_req_valid, core_rdata); else n_pass++;
  endtask

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    core_re       = 1'b1;
    core_addr     = 32'h300;
    bus_req_ready = 1'b0;
    tick();
    repeat (15) tick();
    n_total++; if ({bus_req_valid, core_stall} !== 2'b11) $display("FAIL to_before: got valid,stall=%b want 11", {bus_req_valid, core_stall}); else n_pass++;
    tick();
    n_total++; if ({bus_req_valid, core_stall, core_err} !== 3'b001)
      $display("FAIL to_done: got valid,stall,err=%b want 001", {bus_req_valid, core_stall, core_err});
    else n_pass++;
    n_total++; if (core_rdata !== 32'd0) $display("FAIL to_rdata: got %h want 0", core_rdata); else n_pass++;
    idle_inputs();
    tick();
    n_total++; if ({bus_req_valid, core_stall, core_err} !== 3'b001)
      $display("FAIL to_idle: got valid,stall,err=%b want 001", {bus_req_valid, core_stall, core_err});
    else n_pass++;
  endtask
`else
  task automatic test_wait();
    core_re       = 1'b1;
    core_addr     = 32'h300;
    bus_req_ready = 1'b0;
    tick();
    repeat (40) tick();
    n_total++; if ({bus_req_valid, core_stall, core_err} !== 3'b110)
      $display("FAIL wait_hold: got valid,stall,err=%b want 110", {bus_req_valid, core_stall, core_err});
    else n_pass++;
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b1;
    bus_resp_data  = 32'h0BAD_F00D;
    tick();
    n_total++; if ({core_stall, core_rdata} !== {1'b0, 32'h0BAD_F00D}) $display("FAIL wait_done: got stall=%b rdata=%h want 0 0badf00d", core_stall, core_rdata); else n_pass++;
    idle_inputs();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_store();
    test_error();
    test_reset_mid();
    test_back_to_back();
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    test_timeout();
`else
    test_wait();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
